// File: rtl/ram_sp_async_read.sv
// rtl/ram_sp_async_read.sv - single-port RAM, synchronous write, combinational read
module ram_sp_async_read #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Every address value must map to a real word, so the array is exactly 2**ADDR_WIDTH deep.
    if (DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_check
        $error("ram_sp_async_read: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (write_en) begin
            mem_d[address] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // No bypass: a same-address write only shows up after the edge that commits it.
    assign data_out = mem_q[address];

endmodule

// File: tb/tb_ram_sp_async_read.sv
// tb/tb_ram_sp_async_read.sv - scoreboard bench for ram_sp_async_read
`timescale 1ns/1ps
module tb_ram_sp_async_read;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [3:0] address = 4'h0;
    logic       write_en = 1'b0;
    logic [7:0] data_out;

    ram_sp_async_read #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .address(address),
        .write_en(write_en),
        .data_out(data_out)
    );

    // 1us period; the clock can be frozen low for the stopped-clock reset test.
    initial begin
        forever begin
            #500;
            if (clk_en || clk) clk = ~clk;
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];
    string      name_q [$];
    logic       sample_stb = 1'b0;

    // Monitor: every sample strobe pops one expected value and compares it.
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(posedge sample_stb);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: strobe with no expected value, data_out=%h", data_out);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL %s: addr=%0d got %h expected %h", nm, address, data_out, e);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    endtask

    // Present an address, push the model's expectation, sample 100ns later with no clock edge needed.
    task automatic rd(input int idx, input string nm);
        address = idx[3:0];
        exp_q.push_back(ref_mem[idx % 16]);
        name_q.push_back(nm);
        #100;
        sample_stb = 1'b1;
        #1;
        sample_stb = 1'b0;
    endtask

    // Drive just after a posedge, commit on the next posedge, then update the model.
    task automatic wr(input int idx, input logic [7:0] d);
        @(posedge clk);
        #1;
        write_en = 1'b1;
        address  = idx[3:0];
        data_in  = d;
        @(posedge clk);
        #1;
        if (rst_n) ref_mem[idx % 16] = d;
        write_en = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [17];
        model_reset();
        #1700;
        rd(0, "reset_hold_addr0");
        rd(15, "reset_hold_addr15");
        @(negedge clk);
        rst_n = 1'b1;

        // 1. reset clear with the clock stopped
        wr(2, 8'hA5);
        rd(2, "pre_reset_a5");
        clk_en = 1'b0;
        #1200;
        rst_n = 1'b0;
        model_reset();
        #200;
        rd(2, "reset_low_addr2");
        rst_n = 1'b1;
        #100;
        for (int i = 0; i < 16; i++) rd(i, "reset_clear");
        clk_en = 1'b1;

        // 2. write then read back
        wr(3, 8'h24);
        rd(3, "write_readback");

        // 3. async read switching address, clock frozen
        wr(7, 8'h11);
        wr(8, 8'h22);
        clk_en = 1'b0;
        #1200;
        rd(7, "async_read_7");
        rd(8, "async_read_8");
        rd(7, "async_read_7b");
        clk_en = 1'b1;

        // 4. full sweep 0..16 with wrap
        for (int i = 0; i < 17; i++) begin
            logic [7:0] v;
            do begin
                v = 8'($urandom_range(0, 255));
            end while (i > 0 && v == vals[0]);
            vals[i] = v;
            wr(i, v);
            rd(i, "sweep_readback");
        end
        rd(0, "wrap_addr0");
        for (int i = 1; i < 16; i++) rd(i, "sweep_retain");

        // read-during-write: old contents before the edge, new after
        @(posedge clk);
        #1;
        write_en = 1'b1;
        data_in  = ~ref_mem[4];
        rd(4, "rdw_before_edge");
        @(posedge clk);
        #1;
        ref_mem[4] = data_in;
        write_en = 1'b0;
        rd(4, "rdw_after_edge");

        // 5. write disabled for three edges
        wr(5, 8'h3C);
        data_in = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            rd(5, "write_disabled");
        end

        // random mixed traffic against the model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 15), 8'($urandom_range(0, 255)));
            else rd($urandom_range(0, 15), "random_read");
        end

        // 6. reset dropped during a write cycle
        @(posedge clk);
        #1;
        write_en = 1'b1;
        address  = 4'd6;
        data_in  = 8'h77;
        #100;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rd(6, "reset_during_write_addr6");
        write_en = 1'b0;
        for (int i = 0; i < 16; i++) rd(i, "reset_mid_clear");
        rst_n = 1'b1;
        wr(9, 8'h5A);
        rd(9, "post_reset_write");
        rd(6, "pending_write_lost");

        #10;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
